// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 32-bit column per clock through a
// single shared GF(2^8) column multiplier, valid/ready on both sides.
module inv_mix_columns_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] stateIn,
  input  logic         inValid,
  output logic         inReady,
  output logic [127:0] stateOut,
  output logic         outValid,
  input  logic         outReady
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [1:0]   col_q;
  logic [127:0] work_q;
  logic         load;
  logic         busy;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(
    input logic [7:0] b
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] m0b(
    input logic [7:0] b
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] m0d(
    input logic [7:0] b
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] m0e(
    input logic [7:0] b
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Shared column multiplier; col_q steers the word in.
  assign col_in = work_q[{col_q, 5'd0} +: 32];

  always_comb begin
    logic [7:0] s0, s1, s2, s3;
    s0 = col_in[31:24];
    s1 = col_in[23:16];
    s2 = col_in[15:8];
    s3 = col_in[7:0];
    col_out[31:24] = m0e(s0) ^ m0b(s1)
                   ^ m0d(s2) ^ m09(s3);
    col_out[23:16] = m09(s0) ^ m0e(s1)
                   ^ m0b(s2) ^ m0d(s3);
    col_out[15:8]  = m0d(s0) ^ m09(s1)
                   ^ m0e(s2) ^ m0b(s3);
    col_out[7:0]   = m0b(s0) ^ m0d(s1)
                   ^ m09(s2) ^ m0e(s3);
  end

  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    load     = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        inReady  = outReady;
        if (outReady) begin
          if (inValid) begin
            load    = 1'b1;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= 2'd0;
      work_q   <= 128'h0;
      stateOut <= 128'h0;
    end else begin
      state_q <= state_d;
      if (load) begin
        work_q <= stateIn;
        col_q  <= 2'd0;
      end else if (busy) begin
        col_q <= col_q + 2'd1;
      end
      if (busy) stateOut[{col_q, 5'd0} +: 32] <= col_out;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: directed vectors plus a random
// MixColumns round-trip against a generic GF(2^8) matrix model.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst_n;
  logic [127:0] stateIn;
  logic         inValid;
  logic         inReady;
  logic [127:0] stateOut;
  logic         outValid;
  logic         outReady;

  int vec_cnt = 0;
  int err_cnt = 0;

  inv_mix_columns_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stateIn  (stateIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .stateOut (stateOut),
    .outValid (outValid),
    .outReady (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] aa;
    logic [7:0] p;
    p  = 8'h00;
    aa = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] mat_apply(
    input logic [127:0] s,
    input logic [7:0]   k0,
    input logic [7:0]   k1,
    input logic [7:0]   k2,
    input logic [7:0]   k3
  );
    logic [7:0] row [4];
    logic [7:0] in_b [4];
    logic [7:0] acc;
    logic [127:0] r;
    row[0] = k0;
    row[1] = k1;
    row[2] = k2;
    row[3] = k3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++)
        in_b[j] = s[32*c + 24 - 8*j +: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        // circulant: entry (i,j) is row[(j-i) mod 4]
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(row[(j - i + 4) % 4], in_b[j]);
        r[32*c + 24 - 8*i +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(
    input logic [127:0] s
  );
    return mat_apply(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] mix(
    input logic [127:0] s
  );
    return mat_apply(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer d until accepted; returns just after the handshake edge.
  task automatic push(input logic [127:0] d);
    int n;
    n = 0;
    inValid = 1'b1;
    stateIn = d;
    forever begin
      @(negedge clk);
      if (inReady) break;
      n++;
      if (n > 200) begin
        chk("push_timeout", 128'd0, 128'd1);
        break;
      end
    end
    step();
    inValid = 1'b0;
    stateIn = rnd128();
  endtask

  // Waits for outValid, checks latency and data, lets handshake occur.
  task automatic pull(
    input string        tag,
    input logic [127:0] exp
  );
    int k;
    k = 0;
    outReady = 1'b1;
    forever begin
      @(negedge clk);
      if (outValid) break;
      k++;
      if (k > 50) break;
    end
    chk({tag, "_lat"}, 128'(k), 128'd4);
    chk({tag, "_data"}, stateOut, exp);
    step();
  endtask

  logic [127:0] fips_in;
  logic [127:0] fips_out;
  logic [127:0] held;
  logic [127:0] va;
  logic [127:0] vb;
  logic [127:0] expq [$];
  int           got_n;

  initial begin
    fips_in  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    fips_out = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    stateIn  = '0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out", stateOut, 128'h0);
    chk("rst_ov", 128'(outValid), 128'd0);
    chk("rst_ir", 128'(inReady), 128'd1);
    step();

    chk("model_fips", inv_mix(fips_in), fips_out);
    push(fips_in);
    pull("fips", fips_out);

    push({4{32'hc6c6c6c6}});
    pull("c6", {4{32'hc6c6c6c6}});
    push(128'h0);
    pull("zero", 128'h0);

    // back-to-back with inValid and outReady held high
    va = rnd128();
    vb = rnd128();
    inValid  = 1'b1;
    stateIn  = va;
    outReady = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      chk($sformatf("b2b_ir%0d", cyc), 128'(inReady),
          128'(cyc == 0 || cyc == 5 || cyc >= 10));
      chk($sformatf("b2b_ov%0d", cyc), 128'(outValid),
          128'(cyc == 5 || cyc == 10));
      if (cyc == 5) chk("b2b_a", stateOut, inv_mix(va));
      if (cyc == 10) chk("b2b_b", stateOut, inv_mix(vb));
      step();
      if (cyc == 0) stateIn = vb;
      if (cyc == 5) inValid = 1'b0;
    end

    // backpressure
    outReady = 1'b0;
    va = rnd128();
    push(va);
    inValid = 1'b1;
    stateIn = rnd128();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (outValid) break;
    end
    held = stateOut;
    chk("bp_data", held, inv_mix(va));
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      chk("bp_ov", 128'(outValid), 128'd1);
      chk("bp_hold", stateOut, held);
      chk("bp_ir", 128'(inReady), 128'd0);
    end
    step();
    inValid  = 1'b0;
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    @(negedge clk);
    chk("bp_release", 128'(outValid), 128'd0);
    outReady = 1'b1;
    step();

    // reset at the second BUSY cycle
    push(rnd128());
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_out", stateOut, 128'h0);
    chk("mrst_ov", 128'(outValid), 128'd0);
    chk("mrst_ir", 128'(inReady), 128'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("mrst_quiet", 128'(outValid), 128'd0);
    end
    step();
    push(fips_in);
    pull("mrst_next", fips_out);

    // random round-trip through MixColumns with stalls
    got_n = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [127:0] o;
          o = rnd128();
          if ($urandom_range(0, 3) == 0) step();
          expq.push_back(o);
          push(mix(o));
        end
      end
      begin
        for (int t = 0; t < 40000 && got_n < 1000; t++) begin
          @(posedge clk);
          #1;
          outReady = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (outValid && outReady) begin
            if (expq.size() == 0) begin
              chk("rt_extra", 128'd1, 128'd0);
            end else begin
              chk("rt", stateOut, expq.pop_front());
            end
            got_n++;
          end
        end
        chk("rt_count", 128'(got_n), 128'd1000);
      end
    join
    step();
    step();
    chk("rt_left", 128'(expq.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
